greyscale_ctrl: RTL and testbench

GREYSCALE_CTRL -- requirements
Module: greyscale_ctrl

---
 rtl/greyscale_ctrl.sv | 176 +++++++++++++++++
 tb/tb_greyscale_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/greyscale_ctrl.sv
// greyscale_ctrl: frame-capture sequencer for a 2x2 greyscale datapath.
// It tracks the column and row of accepted sensor pixels, drives the
// line-buffer shift and 2x2 register enables, and emits one output pixel
// per 2x2 block at the block's bottom-right corner.
// Optional build macro GREY_CTRL_LINECHK_EN enables the sticky line-length
// check on in_eol. Without it, in_eol is ignored and err is tied low.
module greyscale_ctrl #(
   parameter int IMG_W = 1280,
   parameter int IMG_H = 960,
   parameter int CW    = 12,
   parameter int RW    = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic          in_valid,
   input  logic          in_eol,
   output logic          tap_shift,
   output logic          pipe_en,
   output logic          out_valid,
   output logic [CW-2:0] out_x,
   output logic [RW-2:0] out_y,
   output logic          busy,
   output logic          frame_done,
   output logic          err
);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      RUN,
      DONE
   } state_t;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          out_valid_q, out_valid_d;
   logic [CW-2:0] out_x_q, out_x_d;
   logic [RW-2:0] out_y_q, out_y_d;

   logic          capturing;
   logic          accept;
   logic          colLast;
   logic          rowLast;
   logic          startTaken;

   // Pixel acceptance and frame-position decode shared by the FSM and the outputs.
   always_comb begin
      capturing  = (state_q == FILL) || (state_q == RUN);
      accept     = in_valid && capturing;
      colLast    = (col_q == COL_LAST);
      rowLast    = (row_q == ROW_LAST);
      startTaken = (state_q == IDLE) && start && !abort;
   end

   // Next-state logic for the frame FSM and the column/row position counters.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      unique case (state_q)
         IDLE: begin
            if (startTaken) begin
               state_d = FILL;
               col_d   = '0;
               row_d   = '0;
            end
         end
         FILL, RUN: begin
            if (accept) begin
               if (colLast) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
               // The first full line primes the line buffer; output work starts after it.
               if (state_q == FILL && colLast && row_q == '0) begin
                  state_d = RUN;
               end
               // The row counter is cleared rather than allowed to run past the frame.
               if (state_q == RUN && colLast && rowLast) begin
                  state_d = DONE;
                  row_d   = '0;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Abort overrides everything, including a simultaneous last pixel.
      if (abort) begin
         state_d = IDLE;
         col_d   = '0;
         row_d   = '0;
      end
   end

   // An output pixel is produced at the odd/odd corner of each 2x2 block.
   always_comb begin
      out_valid_d = accept && (state_q == RUN) && col_q[0] && row_q[0] && !abort;
      out_x_d     = out_x_q;
      out_y_d     = out_y_q;
      if (out_valid_d) begin
         out_x_d = col_q[CW-1:1];
         out_y_d = row_q[RW-1:1];
      end
   end

   // State, counters and registered output coordinates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         out_valid_q <= 1'b0;
         out_x_q     <= '0;
         out_y_q     <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         out_valid_q <= out_valid_d;
         out_x_q     <= out_x_d;
         out_y_q     <= out_y_d;
      end
   end

`ifdef GREY_CTRL_LINECHK_EN
   logic err_q, err_d;

   // Sticky error when in_eol disagrees with the last-column position of an accepted pixel.
   always_comb begin
      err_d = err_q;
      if (startTaken) begin
         err_d = 1'b0;
      end else if (accept && (in_eol != colLast)) begin
         err_d = 1'b1;
      end
   end

   // Error flag register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unusedEol;

   assign unusedEol = in_eol;
   assign err       = 1'b0;
`endif

   assign tap_shift  = accept;
   assign pipe_en    = in_valid && (state_q == RUN);
   assign busy       = capturing;
   assign frame_done = (state_q == DONE) && !abort;
   assign out_valid  = out_valid_q;
   assign out_x      = out_x_q;
   assign out_y      = out_y_q;

endmodule

// File: tb/tb_greyscale_ctrl.sv
// tb_greyscale_ctrl: self-checking bench for greyscale_ctrl on a 4x4 frame.
// A frame-level model (pixel count within the frame) predicts every output
// on every falling edge; literal expectations pin the directed scenarios.
module tb_greyscale_ctrl;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int CW = 3;
   localparam int RW = 3;
`ifdef GREY_CTRL_LINECHK_EN
   localparam bit LINECHK = 1'b1;
`else
   localparam bit LINECHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_eol = 1'b0;
   logic          tap_shift;
   logic          pipe_en;
   logic          out_valid;
   logic [CW-2:0] out_x;
   logic [RW-2:0] out_y;
   logic          busy;
   logic          frame_done;
   logic          err;

   int vectors = 0;
   int miscompares = 0;
   bit cmpEn = 1'b0;

   // Model state: whether a frame is being captured, how many pixels of it were taken.
   bit mActive, mDone, mOutValid, mErr;
   int mPix, mOutX, mOutY;
   bit mAcc;
   int mCol, mRow;

   // Observation counters for the directed literal checks.
   int outCount, doneCount, tapCount, pipeCount;
   int obsX[$];
   int obsY[$];

   greyscale_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CW), .RW(RW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_eol    (in_eol),
      .tap_shift (tap_shift),
      .pipe_en   (pipe_en),
      .out_valid (out_valid),
      .out_x     (out_x),
      .out_y     (out_y),
      .busy      (busy),
      .frame_done(frame_done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit v, input bit e, input bit s, input bit a);
      @(posedge clk);
      #1;
      in_valid = v;
      in_eol   = e;
      start    = s;
      abort    = a;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Send n pixels with frame indices first..first+n-1; eol is flipped at badIdx.
   task automatic sendPixels(input int n, input int first, input bit gapped, input int badIdx);
      for (int i = 0; i < n; i++) begin
         int idx;
         bit e;
         idx = first + i;
         e   = ((idx % W) == W - 1) ^ (idx == badIdx);
         applyStimulus(1'b1, e, 1'b0, 1'b0);
         if (gapped) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic clearMon();
      outCount  = 0;
      doneCount = 0;
      tapCount  = 0;
      pipeCount = 0;
      obsX.delete();
      obsY.delete();
   endtask

   task automatic checkFourOutputs(input string tag);
      int expX[4];
      int expY[4];
      expX = '{0, 1, 0, 1};
      expY = '{0, 0, 1, 1};
      checkOutput({tag, "_outCount"}, outCount, 4);
      checkOutput({tag, "_doneCount"}, doneCount, 1);
      for (int i = 0; i < 4; i++) begin
         checkOutput({tag, "_x"}, (obsX.size() > i) ? obsX[i] : -1, expX[i]);
         checkOutput({tag, "_y"}, (obsY.size() > i) ? obsY[i] : -1, expY[i]);
      end
   endtask

   // Frame-level reference: position comes from the count of accepted pixels.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mActive = 0; mDone = 0; mPix = 0; mOutValid = 0;
         mOutX = 0; mOutY = 0; mErr = 0;
      end else begin
         mAcc = in_valid && mActive;
         mCol = mPix % W;
         mRow = mPix / W;
         if (LINECHK && mAcc && (in_eol != (mCol == W - 1))) mErr = 1;
         mOutValid = 0;
         if (abort) begin
            mActive = 0; mDone = 0; mPix = 0;
         end else if (mDone) begin
            mDone = 0;
         end else if (!mActive) begin
            if (start) begin
               mActive = 1; mPix = 0; mErr = 0;
            end
         end else if (mAcc) begin
            if ((mCol % 2 == 1) && (mRow % 2 == 1)) begin
               mOutValid = 1; mOutX = mCol / 2; mOutY = mRow / 2;
            end
            mPix++;
            if (mPix == W * H) begin
               mActive = 0; mDone = 1; mPix = 0;
            end
         end
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      if (cmpEn) begin
         checkOutput("busy", busy, mActive);
         checkOutput("tap_shift", tap_shift, in_valid && mActive);
         checkOutput("pipe_en", pipe_en, in_valid && mActive && (mPix >= W));
         checkOutput("frame_done", frame_done, mDone && !abort);
         checkOutput("out_valid", out_valid, mOutValid);
         if (mOutValid) begin
            checkOutput("out_x", int'(out_x), mOutX);
            checkOutput("out_y", int'(out_y), mOutY);
         end else begin
            checkOutput("out_x_hold", int'(out_x), mOutX);
            checkOutput("out_y_hold", int'(out_y), mOutY);
         end
         checkOutput("err", err, mErr);
      end
   end

   // Collect DUT events for the directed literal checks.
   always @(negedge clk) begin
      if (out_valid) begin
         outCount++;
         obsX.push_back(int'(out_x));
         obsY.push_back(int'(out_y));
      end
      if (frame_done) doneCount++;
      if (tap_shift) tapCount++;
      if (pipe_en) pipeCount++;
   end

   initial begin
      clearMon();
      repeat (2) @(posedge clk);
      #1;
      cmpEn = 1'b1;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_frame_done", frame_done, 0);
      checkOutput("reset_err", err, 0);
      rst = 1'b0;
      idleCycles(2);

      $display("[TB] nominal frame");
      clearMon();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      sendPixels(16, 0, 1'b0, -1);
      idleCycles(3);
      checkFourOutputs("nominal");
      checkOutput("nominal_tapCount", tapCount, 16);
      checkOutput("nominal_pipeCount", pipeCount, 12);

      $display("[TB] gapped frame");
      clearMon();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      sendPixels(16, 0, 1'b1, -1);
      idleCycles(3);
      checkFourOutputs("gapped");
      checkOutput("gapped_tapCount", tapCount, 16);
      checkOutput("gapped_pipeCount", pipeCount, 12);

      $display("[TB] abort on last pixel");
      clearMon();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      sendPixels(15, 0, 1'b0, -1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("abort_busy", busy, 0);
      idleCycles(2);
      checkOutput("abort_outCount", outCount, 3);
      checkOutput("abort_doneCount", doneCount, 0);
      clearMon();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      sendPixels(16, 0, 1'b0, -1);
      idleCycles(3);
      checkFourOutputs("restart");

      $display("[TB] reset mid-frame");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      sendPixels(9, 0, 1'b0, -1);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      rst = 1'b1;
      #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_tap_shift", tap_shift, 0);
      checkOutput("rst_pipe_en", pipe_en, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_x", int'(out_x), 0);
      checkOutput("rst_out_y", int'(out_y), 0);
      checkOutput("rst_frame_done", frame_done, 0);
      checkOutput("rst_err", err, 0);
      idleCycles(2);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clearMon();
      sendPixels(6, 0, 1'b0, -1);
      idleCycles(1);
      checkOutput("postrst_tapCount", tapCount, 0);
      checkOutput("postrst_outCount", outCount, 0);

      $display("[TB] line-length error");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      sendPixels(16, 0, 1'b0, 6);
      idleCycles(3);
      checkOutput("lineerr_held", err, LINECHK ? 1 : 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lineerr_cleared", err, 0);
      sendPixels(16, 0, 1'b0, -1);
      idleCycles(3);

      $display("[TB] start during RUN");
      clearMon();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      sendPixels(8, 0, 1'b0, -1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      sendPixels(7, 9, 1'b0, -1);
      idleCycles(3);
      checkFourOutputs("startrun");

      $display("[TB] random traffic");
      for (int i = 0; i < 1500; i++) begin
         bit v, s, a, e;
         v = ($urandom % 4) != 0;
         s = ($urandom % 16) == 0;
         a = ($urandom % 97) == 0;
         e = ((mPix % W) == W - 1) ^ (($urandom % 50) == 0);
         applyStimulus(v, e, s, a);
      end
      idleCycles(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
